// File: rtl/word_timing_pkg.sv
// Shared word-timing definitions: revolution geometry, word-time type and sync states.
package word_timing_pkg;
   localparam int WORDS_PER_REV = 108;

   typedef logic [6:0] wt_t;

   localparam wt_t LAST_WORD = wt_t'(WORDS_PER_REV - 1);

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } sync_state_t;
endpackage

// File: rtl/word_timing_if.sv
// Word-timing bundle: T29/index/location in, word time and flags out.
interface word_timing_if;
   import word_timing_pkg::*;

   logic T29;
   logic IDX;
   logic [6:0] L;
   wt_t  WT;
   logic CE;
   logic CF;
   logic CN;
   logic WT_EQ_L;
   logic SYNC;
   logic SYNC_ERR;

   modport master (
      output T29, IDX, L,
      input  WT, CE, CF, CN, WT_EQ_L, SYNC, SYNC_ERR
   );

   modport slave (
      input  T29, IDX, L,
      output WT, CE, CF, CN, WT_EQ_L, SYNC, SYNC_ERR
   );
endinterface

// File: rtl/word_timing_word_ctr.sv
// Modulo-108 word-time counter with T29 enable and synchronous load-zero.
module word_ctr
   import word_timing_pkg::*;
(
   input  logic CLOCK,
   input  logic rst_n,
   input  logic en,
   input  logic load_zero,
   output wt_t  wt,
   output wt_t  wt_nxt
);

   always_comb begin
      wt_nxt = wt;
      if (load_zero)
         wt_nxt = '0;
      else if (en)
         wt_nxt = (wt == LAST_WORD) ? '0 : wt + 7'd1;
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n)
         wt <= '0;
      else
         wt <= wt_nxt;
   end

endmodule

// File: rtl/word_timing.sv
// Number-track word timing: hunts for the index mark, then tracks word time 0..107.
//   state | meaning
//   HUNT  | no sync; WT held at 0, waiting for IDX with T29
//   LOCK  | WT advances on T29, index checked at word 107
module word_timing
   import word_timing_pkg::*;
(
   input  logic          CLOCK,
   input  logic          rst_n,
   word_timing_if.slave  bus
);

   sync_state_t state;
   sync_state_t state_nxt;
   logic [1:0]  miss;
   logic [1:0]  miss_nxt;
   logic        load_zero;
   logic        err_set;
   wt_t         wt;
   wt_t         wt_nxt;

   logic ce_q;
   logic cf_q;
   logic cn_q;
   logic eq_q;
   logic sync_q;
   logic err_q;

   word_ctr u_word_ctr (
      .CLOCK     (CLOCK),
      .rst_n     (rst_n),
      .en        (bus.T29),
      .load_zero (load_zero),
      .wt        (wt),
      .wt_nxt    (wt_nxt)
   );

   always_comb begin
      state_nxt = state;
      miss_nxt  = miss;
      load_zero = 1'b0;
      err_set   = 1'b0;
      case (state)
         HUNT: begin
            load_zero = 1'b1;
            if (bus.T29 && bus.IDX) begin
               state_nxt = LOCK;
               miss_nxt  = 2'd0;
            end
         end
         LOCK: begin
            if (bus.T29) begin
               if (wt != LAST_WORD) begin
                  if (bus.IDX) begin
                     err_set   = 1'b1;
                     load_zero = 1'b1;
                  end
               end else if (bus.IDX) begin
                  miss_nxt = 2'd0;
               end else if (miss == 2'd1) begin
                  // second consecutive missing index: give up and hunt again
                  err_set   = 1'b1;
                  load_zero = 1'b1;
                  state_nxt = HUNT;
                  miss_nxt  = 2'd0;
               end else begin
                  miss_nxt = miss + 2'd1;
               end
            end
         end
         default: begin
            state_nxt = HUNT;
            load_zero = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         state  <= HUNT;
         miss   <= 2'd0;
         ce_q   <= 1'b1;
         cf_q   <= 1'b0;
         cn_q   <= 1'b1;
         eq_q   <= 1'b0;
         sync_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         miss   <= miss_nxt;
         ce_q   <= ~wt_nxt[0];
         cf_q   <= wt_nxt[1];
         cn_q   <= ~((state_nxt == LOCK) && (wt_nxt == LAST_WORD));
         sync_q <= (state_nxt == LOCK);
         if (err_set)
            err_q <= 1'b1;
         // L is sampled only at word boundaries
         if (bus.T29)
            eq_q <= (state_nxt == LOCK) && (wt_nxt == bus.L);
      end
   end

   assign bus.WT       = wt;
   assign bus.CE       = ce_q;
   assign bus.CF       = cf_q;
   assign bus.CN       = cn_q;
   assign bus.WT_EQ_L  = eq_q;
   assign bus.SYNC     = sync_q;
   assign bus.SYNC_ERR = err_q;

endmodule

// File: doc/word_timing.md
WORD_TIMING -- requirements
Module: word_timing

Interface
REQ-001 CLOCK  in  1  9.3 uS bit clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 T29  in  1  one-CLOCK pulse per word at bit time 29, from the timing-gate block.
REQ-004 IDX  in  1  number-track index mark; a valid mark is IDX=1 coincident with T29 of physical word 107.
REQ-005 L  in  7  command location field, 0..107; values above 107 never match.
REQ-006 WT  out  7  current word time, 0..107.
REQ-007 CE  out  1  even word time FF; 1 while WT is even.
REQ-008 CF  out  1  mod-2/mod-3 FF; equals WT[1], so it is 1 for words 2,3 of each 4-word group.
REQ-009 CN  out  1  number-track FF; 0 only while WT=107 in LOCK state, else 1.
REQ-010 WT_EQ_L  out  1  1 for the whole word whose WT equals L.
REQ-011 SYNC  out  1  1 while in LOCK state.
REQ-012 SYNC_ERR  out  1  sticky; set on any index/counter disagreement, cleared only by reset.

Function
REQ-013 States SHALL be HUNT and LOCK; WT, CE, CF, CN and WT_EQ_L SHALL be registered, with no combinational path from any input to any output.
REQ-014 HUNT: WT SHALL hold 0, CN SHALL be 1, so timing produces no T0, and WT_EQ_L SHALL be 0.
REQ-015 HUNT, T29=1 and IDX=1: on that edge WT SHALL load 0, the miss count SHALL clear and the state SHALL move to LOCK.
REQ-016 LOCK, T29=1: WT SHALL advance by 1 modulo 108, so 107 wraps to 0; WT SHALL not change on any other edge.
REQ-017 CE, CF and CN SHALL update on the same edge as WT and always be consistent with the new WT value.
REQ-018 LOCK, T29=1, IDX=1, WT/=107: SYNC_ERR SHALL set, WT SHALL load 0 and the state SHALL stay LOCK.
REQ-019 LOCK, T29=1, WT=107, IDX=0: the 2-bit miss count SHALL increment; at the second consecutive miss SHALL set SYNC_ERR and go to HUNT with WT=0.
REQ-020 LOCK, T29=1, WT=107, IDX=1: the miss count SHALL clear.
REQ-021 IDX without T29 SHALL be ignored in both states.
REQ-022 WT_EQ_L SHALL be re-evaluated only on T29 edges, as (next WT == L) and in LOCK; a change of L mid-word SHALL take effect at the next T29.
REQ-023 On every T29 edge, WT_EQ_L SHALL be recomputed from the resynchronised WT, whether that WT comes from a wrap or from a resync load.

Reset
REQ-024 rst_n=0 SHALL immediately give: state HUNT, WT=0, CE=1, CF=0, CN=1, WT_EQ_L=0, SYNC=0, SYNC_ERR=0, miss count 0.
REQ-025 Reset asserted mid-word SHALL abandon the word with no partial update; after release the block SHALL hunt again.

Structure
REQ-026 The g15 shared package SHALL hold WORDS_PER_REV=108, LAST_WORD=107, the 7-bit word-time typedef and the HUNT/LOCK state enum.
REQ-027 One sub-module, word_ctr (modulo-108 counter with synchronous load-zero and T29 enable), is natural; everything else is inline.

Verification
REQ-028 Bench: reset, then T29 every 29 clocks with IDX at word 107 -> SYNC=1 after the first IDX; WT steps 0..107 and wraps; CN=0 only during word 107.
REQ-029 Bench: sweep WT 0..7 -> CE=1,0,1,0,1,0,1,0 and CF=0,0,1,1,0,0,1,1; CF=1 with CE=0 only in word 3 mod 4.
REQ-030 Bench: locked, inject IDX with T29 at WT=50 -> SYNC_ERR=1, next WT=0, SYNC stays 1.
REQ-031 Bench: drop IDX on two successive revolutions -> after the first, still locked with SYNC_ERR=0; after the second, SYNC=0, WT=0 and SYNC_ERR=1.
REQ-032 Bench: L=5 -> WT_EQ_L=1 for exactly 29 clocks of word 5 each revolution; L=110 -> never 1; L changed 3->9 during word 2 -> WT_EQ_L high in word 9, not in word 3.
REQ-033 Bench: assert rst_n low mid-word in LOCK -> outputs at reset values asynchronously; IDX is required again before SYNC=1.
